mux_arbiter: RTL and testbench
==============================

# mux_arbiter

Two-requester arbiter and sequencer for the shared 2:1 datapath MUX. It grants the MUX to one requester at a time, drives the MUX select, and captures the selected beat into a one-entry output register with a valid/ready handshake toward the consumer. Grant ownership is burst-based: a grant holds until LAST, until burst length MAXBURST is reached, or until the requester drops. The arbiter sits between the two producer ports and the shared downstream stage.

## Interface
- WIDTH, 32, data width of IN0/IN1/OUT
- MAXBURST, 4, maximum accepted beats per grant (>=1); counter width is clog2(MAXBURST+1)
- CLK  input  1  clock, all logic on rising edge
- RST  input  1  synchronous, active-high reset
- REQ0  input  1  requester 0 has a valid beat on IN0
- IN0  input  WIDTH  requester 0 data
- LAST0  input  1  current requester 0 beat ends its burst
- ACK0  output  1  requester 0 beat accepted this cycle
- REQ1 / IN1 / LAST1 / ACK1  same as above, for requester 1
- SEL  output  1  MUX select: 1 = IN1, 0 = IN0
- OUT  output  WIDTH  registered selected beat
- OUT_VALID  output  1  OUT holds an unconsumed beat
- OUT_READY  input  1  consumer accepts OUT this cycle
- BUSY  output  1  high in any GRANT state

## Operation
- States: IDLE, GRANT0, GRANT1. SEL=1 only in GRANT1 and is registered with the state. BUSY = state != IDLE.
- IDLE: if only REQn is high, go to GRANTn. If both are high, go to the requester not served last (PRI pointer). No beat is accepted in IDLE.
- ACKn = (state==GRANTn) & REQn & (!OUT_VALID | OUT_READY). This is combinational.
- Accepted beat (REQn & ACKn): OUT <= INn, OUT_VALID <= 1, and the burst counter increments.
- Consumer pop (OUT_VALID & OUT_READY with no new beat): OUT_VALID <= 0. Simultaneous pop and accept keeps OUT_VALID=1 and loads the new data.
- Release of GRANTn happens on any of:
  - an accepted beat with LASTn=1;
  - an accepted beat that brings the counter to MAXBURST;
  - REQn low while granted.
- On release:
  - PRI <= other requester; the counter clears.
  - If the other REQ is high that cycle, go directly to the other GRANT. Otherwise go to IDLE.
- Stall (REQn high, OUT_VALID=1, OUT_READY=0): grant held, ACKn=0, counter unchanged. Stalls never cause release.
- The counter counts only accepted beats. MAXBURST=1 forces alternation every beat when both requesters are active.
- A requester's data and LAST are sampled only on its accepted cycle.

## Timing
- Reset values:
  - state=IDLE, SEL=0, PRI=0 (requester 0 first), counter=0;
  - OUT=0, OUT_VALID=0, ACK0=ACK1=0, BUSY=0.
- Reset mid-operation: any beat in OUT is discarded and the grant is dropped. No ACK is asserted in the reset cycle.
- Arbitration latency from IDLE: REQ seen at edge N, state=GRANTn at N+1, first ACK during cycle N+1.
- Data latency: a beat accepted in cycle N is on OUT with OUT_VALID=1 after edge N+1.
- Full-throughput burst: with OUT_READY held high, one beat per cycle.
- Handover: the cycle after a releasing beat, the other requester is granted and can be ACKed immediately (zero idle cycles).
- Back-to-back bursts by the same requester with the other idle: path GRANTn, then IDLE, then GRANTn (one bubble).

## Configuration
- MUX_ARB_RR_EN defined: round-robin. The PRI pointer is used both in IDLE ties and for direct handover on release.
- MUX_ARB_RR_EN undefined: fixed priority to requester 0.
  - An IDLE tie always grants requester 0.
  - On release of GRANT0, if REQ0 and REQ1 are both high, go to IDLE. Requester 0 is then re-granted, so requester 1 can starve.
  - On release of GRANT1 with REQ0 high, go directly to GRANT0.
  - The PRI register is not implemented.

## Test plan
- Single burst: REQ0 with 3 beats 0xA,0xB,0xC (LAST on 0xC), OUT_READY=1 -> ACK0 in cycles 1-3, OUT=0xA,0xB,0xC in cycles 2-4, SEL=0, then return to IDLE.
- Tie after reset: REQ0=REQ1=1 from cycle 0 -> GRANT0 first; after LAST0, GRANT1 follows next cycle with SEL=1 and no bubble (RR_EN).
- MAXBURST=4: requester 1 streams 6 beats with no LAST while REQ0 is high -> exactly 4 ACK1 pulses, then GRANT0.
- Backpressure: OUT_READY=0 for 3 cycles mid-burst -> ACK low, OUT held stable, counter frozen. Resume with no lost or duplicated beat.
- Reset mid-burst: assert RST while OUT_VALID=1 in GRANT1 -> next cycle IDLE, OUT_VALID=0, SEL=0, PRI=0.
- Fixed priority (macro undefined): REQ0 and REQ1 held high with LAST0 on every beat -> ACK1 never asserts.

Source files
------------

// File: rtl/mux_arbiter.sv
// mux_arbiter: two-requester burst arbiter for the shared 2:1 datapath MUX.
// Grants the MUX to one requester at a time, drives SEL, and captures the
// selected beat into a one-entry output register with a valid/ready handshake.
// A grant ends on LAST, on reaching MAXBURST accepted beats, or when the owner
// drops its request.
// Optional feature: define MUX_ARB_RR_EN for round-robin arbitration; the
// default build uses fixed priority to requester 0.
module mux_arbiter #(
  parameter int WIDTH    = 32,
  parameter int MAXBURST = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0,
  input  logic [WIDTH-1:0] IN0,
  input  logic             LAST0,
  output logic             ACK0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] IN1,
  input  logic             LAST1,
  output logic             ACK1,
  output logic             SEL,
  output logic [WIDTH-1:0] OUT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             BUSY
);

  localparam int CW = $clog2(MAXBURST + 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT0,
    GRANT1
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             sel_q;
  logic             busy_q;
  logic [WIDTH-1:0] out_q;
  logic             out_valid_q;
  logic [CW-1:0]    count;

  logic             room;
  logic             ack0;
  logic             ack1;
  logic             accept;
  logic [WIDTH-1:0] acc_data;
  logic             acc_last;
  logic             at_limit;
  logic             own_req;
  logic             release_grant;

`ifdef MUX_ARB_RR_EN
  logic             pri;
`endif

  // The output register can take a beat when empty or being drained this cycle.
  assign room     = !out_valid_q | OUT_READY;
  assign ack0     = !RST & (state == GRANT0) & REQ0 & room;
  assign ack1     = !RST & (state == GRANT1) & REQ1 & room;
  assign accept   = ack0 | ack1;
  assign acc_data = ack1 ? IN1 : IN0;
  assign acc_last = ack1 ? LAST1 : LAST0;
  assign at_limit = (count == CW'(MAXBURST - 1));
  assign own_req  = (state == GRANT1) ? REQ1 : REQ0;

  // Release only on owner drop or an accepted beat that ends the burst; stalls never release.
  assign release_grant = (state != IDLE) & (!own_req | (accept & (acc_last | at_limit)));

  assign ACK0      = ack0;
  assign ACK1      = ack1;
  assign SEL       = sel_q;
  assign BUSY      = busy_q;
  assign OUT       = out_q;
  assign OUT_VALID = out_valid_q;

  // Next-state selection: IDLE arbitration and handover on release.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (REQ0 && REQ1) begin
`ifdef MUX_ARB_RR_EN
          next_state = pri ? GRANT1 : GRANT0;
`else
          next_state = GRANT0;
`endif
        end else if (REQ0) begin
          next_state = GRANT0;
        end else if (REQ1) begin
          next_state = GRANT1;
        end
      end
      GRANT0: begin
        if (release_grant) begin
`ifdef MUX_ARB_RR_EN
          next_state = REQ1 ? GRANT1 : IDLE;
`else
          next_state = (REQ1 && !REQ0) ? GRANT1 : IDLE;
`endif
        end
      end
      GRANT1: begin
        if (release_grant) begin
          next_state = REQ0 ? GRANT0 : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register with registered SEL/BUSY, burst counter and output beat register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      sel_q       <= 1'b0;
      busy_q      <= 1'b0;
      count       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state  <= next_state;
      sel_q  <= (next_state == GRANT1);
      busy_q <= (next_state != IDLE);

      if (release_grant) begin
        count <= '0;
      end else if (accept) begin
        count <= count + 1'b1;
      end

      if (accept) begin
        out_q       <= acc_data;
        out_valid_q <= 1'b1;
      end else if (OUT_READY) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef MUX_ARB_RR_EN
  // Priority pointer flips to the other requester whenever a grant is released.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pri <= 1'b0;
    end else if (release_grant) begin
      pri <= (state == GRANT0);
    end
  end
`endif

endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: directed scenarios with literal expectations followed by
// randomized traffic, all checked every cycle against a behavioural model of
// the arbiter's grant, burst and output-register rules.
// Honours MUX_ARB_RR_EN the same way as the design.
module tb_mux_arbiter;

  localparam int WIDTH    = 32;
  localparam int MAXBURST = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0 = 1'b0;
  logic [WIDTH-1:0] in0 = '0;
  logic             last0 = 1'b0;
  logic             ack0;
  logic             req1 = 1'b0;
  logic [WIDTH-1:0] in1 = '0;
  logic             last1 = 1'b0;
  logic             ack1;
  logic             sel;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             busy;

  int checks = 0;
  int errors = 0;

  // Model state: owner -1 = nobody, else requester index.
  bit               armed = 1'b0;
  int               m_owner = -1;
  int               m_beats = 0;
  logic [WIDTH-1:0] m_out = '0;
  bit               m_valid = 1'b0;
`ifdef MUX_ARB_RR_EN
  int               m_pri = 0;
`endif

  mux_arbiter #(.WIDTH(WIDTH), .MAXBURST(MAXBURST)) dut (
    .CLK(clk), .RST(rst),
    .REQ0(req0), .IN0(in0), .LAST0(last0), .ACK0(ack0),
    .REQ1(req1), .IN1(in1), .LAST1(last1), .ACK1(ack1),
    .SEL(sel), .OUT(out), .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .BUSY(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit q0, input logic [31:0] d0, input bit l0,
                               input bit q1, input logic [31:0] d1, input bit l1, input bit rdy);
    @(posedge clk);
    #1;
    rst       = r;
    req0      = q0;
    in0       = d0;
    last0     = l0;
    req1      = q1;
    in1       = d1;
    last1     = l1;
    out_ready = rdy;
  endtask

  // Compare DUT against the model mid-cycle, then advance the model across the next edge.
  always @(negedge clk) begin : compare
    bit               e_ack0;
    bit               e_ack1;
    bit               acc;
    bit               rel;
    bit               rq [2];
    bit               lst [2];
    logic [WIDTH-1:0] dat [2];
    int               n;
    rq[0] = req0;  rq[1] = req1;
    lst[0] = last0; lst[1] = last1;
    dat[0] = in0;  dat[1] = in1;
    e_ack0 = !rst && (m_owner == 0) && req0 && (!m_valid || out_ready);
    e_ack1 = !rst && (m_owner == 1) && req1 && (!m_valid || out_ready);
    if (armed) begin
      checkOutput("model_ack0", 32'(ack0), 32'(e_ack0));
      checkOutput("model_ack1", 32'(ack1), 32'(e_ack1));
      checkOutput("model_sel", 32'(sel), 32'(m_owner == 1));
      checkOutput("model_busy", 32'(busy), 32'(m_owner != -1));
      checkOutput("model_out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) checkOutput("model_out", out, m_out);
    end
    if (rst) begin
      m_owner = -1;
      m_beats = 0;
      m_out   = '0;
      m_valid = 1'b0;
`ifdef MUX_ARB_RR_EN
      m_pri   = 0;
`endif
      armed   = 1'b1;
    end else if (armed) begin
      acc = e_ack0 || e_ack1;
      if (acc) begin
        n       = e_ack1 ? 1 : 0;
        m_out   = dat[n];
        m_valid = 1'b1;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      if (m_owner == -1) begin
        if (rq[0] && rq[1]) begin
`ifdef MUX_ARB_RR_EN
          m_owner = m_pri;
`else
          m_owner = 0;
`endif
        end else if (rq[0]) m_owner = 0;
        else if (rq[1]) m_owner = 1;
      end else begin
        n   = m_owner;
        rel = !rq[n] || (acc && (lst[n] || (m_beats + 1 == MAXBURST)));
        if (rel) begin
          m_beats = 0;
`ifdef MUX_ARB_RR_EN
          m_pri   = 1 - n;
          m_owner = rq[1-n] ? 1 - n : -1;
`else
          if (!rq[1-n]) m_owner = -1;
          else if (n == 0 && rq[0]) m_owner = -1;
          else m_owner = 1 - n;
`endif
        end else if (acc) begin
          m_beats++;
        end
      end
    end
  end

  initial begin
    logic [7:0] hist1;
    logic [7:0] hist0;
    int         cnt1;

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    #2;
    checkOutput("reset_ack0", 32'(ack0), 32'd0);
    checkOutput("reset_ack1", 32'(ack1), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_sel", 32'(sel), 32'd0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out", out, 32'd0);

    // Single burst A,B,C from requester 0
    applyStimulus(0, 1, 32'hA, 0, 0, 0, 0, 1); #2;
    checkOutput("burst_idle_ack0", 32'(ack0), 32'd0);
    checkOutput("burst_idle_busy", 32'(busy), 32'd0);
    applyStimulus(0, 1, 32'hA, 0, 0, 0, 0, 1); #2;
    checkOutput("burst_c1_ack0", 32'(ack0), 32'd1);
    checkOutput("burst_c1_sel", 32'(sel), 32'd0);
    checkOutput("burst_c1_busy", 32'(busy), 32'd1);
    applyStimulus(0, 1, 32'hB, 0, 0, 0, 0, 1); #2;
    checkOutput("burst_c2_ack0", 32'(ack0), 32'd1);
    checkOutput("burst_c2_out", out, 32'hA);
    checkOutput("burst_c2_valid", 32'(out_valid), 32'd1);
    applyStimulus(0, 1, 32'hC, 1, 0, 0, 0, 1); #2;
    checkOutput("burst_c3_ack0", 32'(ack0), 32'd1);
    checkOutput("burst_c3_out", out, 32'hB);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1); #2;
    checkOutput("burst_c4_out", out, 32'hC);
    checkOutput("burst_c4_busy", 32'(busy), 32'd0);
    checkOutput("burst_c4_ack0", 32'(ack0), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1); #2;
    checkOutput("burst_c5_valid", 32'(out_valid), 32'd0);

    // MAXBURST: requester 1 streams without LAST while requester 0 waits
    applyStimulus(0, 0, 0, 0, 1, $urandom, 0, 1);
    hist1 = '0;
    hist0 = '0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, $urandom, 0, 1, $urandom, 0, 1); #2;
      hist1[i] = ack1;
      hist0[i] = ack0;
      if (i == 4) checkOutput("maxburst_handover_sel", 32'(sel), 32'd0);
    end
    checkOutput("maxburst_ack1_pattern", 32'(hist1), 32'h0F);
    checkOutput("maxburst_ack0_pattern", 32'(hist0), 32'hF0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);

    // Backpressure mid-burst: counter must freeze while stalled
    applyStimulus(0, 1, 32'd1, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 32'd1, 0, 0, 0, 0, 1); #2;
    checkOutput("bp_c1_ack0", 32'(ack0), 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 32'd2, 0, 0, 0, 0, 0); #2;
      checkOutput("bp_stall_ack0", 32'(ack0), 32'd0);
      checkOutput("bp_stall_out", out, 32'd1);
    end
    applyStimulus(0, 1, 32'd2, 0, 0, 0, 0, 1); #2;
    checkOutput("bp_resume_ack0", 32'(ack0), 32'd1);
    checkOutput("bp_resume_out", out, 32'd1);
    applyStimulus(0, 1, 32'd3, 0, 0, 0, 0, 1); #2;
    checkOutput("bp_c6_out", out, 32'd2);
    applyStimulus(0, 1, 32'd4, 0, 0, 0, 0, 1); #2;
    checkOutput("bp_c7_ack0", 32'(ack0), 32'd1);
    checkOutput("bp_c7_out", out, 32'd3);
    applyStimulus(0, 1, 32'd5, 0, 0, 0, 0, 1); #2;
    checkOutput("bp_bubble_busy", 32'(busy), 32'd0);
    checkOutput("bp_bubble_out", out, 32'd4);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1); #2;
    checkOutput("bp_regrant_busy", 32'(busy), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);

    // Reset mid-burst in GRANT1 with a beat held in OUT
    applyStimulus(0, 0, 0, 0, 1, 32'h55, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h55, 0, 0); #2;
    checkOutput("rst_g1_ack1", 32'(ack1), 32'd1);
    checkOutput("rst_g1_sel", 32'(sel), 32'd1);
    applyStimulus(1, 0, 0, 0, 1, 32'h66, 0, 0); #2;
    checkOutput("rst_cycle_ack1", 32'(ack1), 32'd0);
    checkOutput("rst_cycle_valid", 32'(out_valid), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1); #2;
    checkOutput("rst_after_busy", 32'(busy), 32'd0);
    checkOutput("rst_after_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_after_sel", 32'(sel), 32'd0);
    checkOutput("rst_after_out", out, 32'd0);
    applyStimulus(0, 1, 32'h77, 1, 1, 32'h88, 1, 1);
    applyStimulus(0, 1, 32'h77, 1, 1, 32'h88, 1, 1); #2;
    checkOutput("rst_tie_sel", 32'(sel), 32'd0);
    checkOutput("rst_tie_ack0", 32'(ack0), 32'd1);

    // Tie with LAST on every beat: alternation (RR) or starvation of requester 1 (fixed)
    cnt1 = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1, $urandom, 1, 1, $urandom, 1, 1); #2;
      if (ack1) cnt1++;
`ifdef MUX_ARB_RR_EN
      if (i == 0) checkOutput("tie_handover_sel", 32'(sel), 32'd1);
`else
      if (i == 0) checkOutput("tie_fixed_busy", 32'(busy), 32'd0);
`endif
    end
`ifdef MUX_ARB_RR_EN
    checkOutput("tie_ack1_count", 32'(cnt1), 32'd5);
`else
    checkOutput("tie_ack1_count", 32'(cnt1), 32'd0);
`endif
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 199) == 0,
                    $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
